// File: rtl/rob_superscalar_pkg.sv
// Shared types and default widths for the superscalar reorder buffer.
// The entry struct is sized by the default XLEN/REG_W constants below.
package rob_pkg;

  localparam int ROB_SIZE_D  = 32;
  localparam int DP_WIDTH_D  = 2;
  localparam int CDB_WIDTH_D = 2;
  localparam int RT_WIDTH_D  = 2;
  localparam int XLEN_D      = 32;
  localparam int REG_W_D     = 5;

  typedef enum logic [0:0] {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } rob_state_e;

  typedef struct packed {
    logic               busy;
    logic               complete;
    logic               mispredict;
    logic [REG_W_D-1:0] dest_reg;
    logic [XLEN_D-1:0]  pc;
    logic [XLEN_D-1:0]  value;
    logic [XLEN_D-1:0]  target;
  } rob_entry_t;

endpackage

// File: rtl/rob_superscalar_retire_select.sv
// Combinational scan of the head window: which lanes retire, how many,
// and which lane (if any) carries the first mispredicted branch.
module rob_retire_select #(
  parameter int RT_WIDTH = 2,
  parameter int CNT_W    = $clog2(RT_WIDTH + 1),
  parameter int LANE_W   = (RT_WIDTH > 1) ? $clog2(RT_WIDTH) : 1
) (
  input  logic                enable,
  input  logic [RT_WIDTH-1:0] busy,
  input  logic [RT_WIDTH-1:0] complete,
  input  logic [RT_WIDTH-1:0] mispredict,
  output logic [RT_WIDTH-1:0] rt_valid,
  output logic [CNT_W-1:0]    rt_count,
  output logic                squash,
  output logic [LANE_W-1:0]   squash_lane
);

  logic go;

  // A lane retires only if every lower lane retired and none of them squashed.
  always_comb begin
    rt_valid    = '0;
    rt_count    = '0;
    squash      = 1'b0;
    squash_lane = '0;
    go          = enable;
    for (int j = 0; j < RT_WIDTH; j++) begin
      if (go && busy[j] && complete[j]) begin
        rt_valid[j] = 1'b1;
        rt_count    = CNT_W'(j + 1);
        if (mispredict[j]) begin
          squash      = 1'b1;
          squash_lane = LANE_W'(j);
          go          = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_superscalar.sv
// N-way reorder buffer: in-order allocate, out-of-order complete, in-order
// retire, operand lookup with CDB bypass, and one-cycle mispredict recovery.
module rob_superscalar
  import rob_pkg::*;
#(
  parameter int ROB_SIZE  = ROB_SIZE_D,
  parameter int DP_WIDTH  = DP_WIDTH_D,
  parameter int CDB_WIDTH = CDB_WIDTH_D,
  parameter int RT_WIDTH  = RT_WIDTH_D,
  parameter int XLEN      = XLEN_D,
  parameter int REG_W     = REG_W_D,
  parameter int TAG_W     = $clog2(ROB_SIZE)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DP_WIDTH-1:0]           dp_valid,
  input  logic [DP_WIDTH*REG_W-1:0]     dp_dest_reg,
  input  logic [DP_WIDTH*XLEN-1:0]      dp_pc,
  output logic                          dp_accept,
  output logic [DP_WIDTH*TAG_W-1:0]     dp_tag,
  input  logic [2*DP_WIDTH*TAG_W-1:0]   src_tag,
  output logic [2*DP_WIDTH-1:0]         src_ready,
  output logic [2*DP_WIDTH*XLEN-1:0]    src_value,
  input  logic [CDB_WIDTH-1:0]          cdb_valid,
  input  logic [CDB_WIDTH*TAG_W-1:0]    cdb_tag,
  input  logic [CDB_WIDTH*XLEN-1:0]     cdb_value,
  input  logic [CDB_WIDTH-1:0]          cdb_mispredict,
  input  logic [CDB_WIDTH*XLEN-1:0]     cdb_target,
  output logic [RT_WIDTH-1:0]           rt_valid,
  output logic [RT_WIDTH*REG_W-1:0]     rt_dest_reg,
  output logic [RT_WIDTH*XLEN-1:0]      rt_value,
  output logic [RT_WIDTH*TAG_W-1:0]     rt_tag,
  output logic                          squash,
  output logic [XLEN-1:0]               squash_pc,
  output logic [TAG_W:0]                count,
  output logic                          empty,
  output rob_state_e                    fsm_state
);

  localparam int PTR_W  = TAG_W + 1;
  localparam int NSRC   = 2 * DP_WIDTH;
  localparam int RCNT_W = $clog2(RT_WIDTH + 1);
  localparam int LANE_W = (RT_WIDTH > 1) ? $clog2(RT_WIDTH) : 1;

  rob_entry_t          rob [ROB_SIZE];
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  rob_state_e          state;
  rob_state_e          state_next;
  logic [PTR_W:0]      free_slots;
  logic [PTR_W-1:0]    dp_num;
  logic [RT_WIDTH-1:0] win_busy;
  logic [RT_WIDTH-1:0] win_complete;
  logic [RT_WIDTH-1:0] win_mispredict;
  logic [TAG_W-1:0]    win_idx [RT_WIDTH];
  logic [RCNT_W-1:0]   rt_count;
  logic [LANE_W-1:0]   squash_lane;

  assign fsm_state  = state;
  assign count      = tail - head;
  assign empty      = (head == tail);
  assign free_slots = (PTR_W + 1)'(ROB_SIZE) - {1'b0, count};
  // Only registered occupancy counts; same-cycle retires do not free space early.
  assign dp_accept  = (state == NORMAL) && (free_slots >= (PTR_W + 1)'(DP_WIDTH));

  for (genvar i = 0; i < DP_WIDTH; i++) begin : g_dp_tag
    assign dp_tag[i*TAG_W +: TAG_W] = tail[TAG_W-1:0] + TAG_W'(i);
  end

  always_comb begin
    dp_num = '0;
    for (int i = 0; i < DP_WIDTH; i++) begin
      if (dp_valid[i]) dp_num = dp_num + 1'b1;
    end
  end

  always_comb begin
    for (int j = 0; j < RT_WIDTH; j++) begin
      win_idx[j]        = head[TAG_W-1:0] + TAG_W'(j);
      win_busy[j]       = rob[win_idx[j]].busy;
      win_complete[j]   = rob[win_idx[j]].complete;
      win_mispredict[j] = rob[win_idx[j]].mispredict;
    end
  end

  rob_retire_select #(
    .RT_WIDTH (RT_WIDTH)
  ) u_retire_select (
    .enable      (state == NORMAL),
    .busy        (win_busy),
    .complete    (win_complete),
    .mispredict  (win_mispredict),
    .rt_valid    (rt_valid),
    .rt_count    (rt_count),
    .squash      (squash),
    .squash_lane (squash_lane)
  );

  always_comb begin
    rt_dest_reg = '0;
    rt_value    = '0;
    rt_tag      = '0;
    squash_pc   = '0;
    for (int j = 0; j < RT_WIDTH; j++) begin
      if (rt_valid[j]) begin
        rt_dest_reg[j*REG_W +: REG_W] = rob[win_idx[j]].dest_reg;
        rt_value[j*XLEN +: XLEN]      = rob[win_idx[j]].value;
        rt_tag[j*TAG_W +: TAG_W]      = win_idx[j];
      end
      if (squash && (squash_lane == LANE_W'(j))) squash_pc = rob[win_idx[j]].target;
    end
  end

  // Completed entries win over the CDB; scanning CDBs downward lets the lowest index win.
  always_comb begin
    logic [TAG_W-1:0] stag;
    stag      = '0;
    src_ready = '0;
    src_value = '0;
    for (int s = 0; s < NSRC; s++) begin
      stag = src_tag[s*TAG_W +: TAG_W];
      if (rob[stag].busy && rob[stag].complete) begin
        src_ready[s]             = 1'b1;
        src_value[s*XLEN +: XLEN] = rob[stag].value;
      end else begin
        for (int c = CDB_WIDTH - 1; c >= 0; c--) begin
          if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == stag)) begin
            src_ready[s]             = 1'b1;
            src_value[s*XLEN +: XLEN] = cdb_value[c*XLEN +: XLEN];
          end
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      NORMAL:  if (squash) state_next = RECOVER;
      RECOVER: state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= NORMAL;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int e = 0; e < ROB_SIZE; e++) rob[e] <= '0;
      head <= '0;
      tail <= '0;
    end else if (state == RECOVER) begin
      head <= head;
    end else if (squash) begin
      // Everything younger than the mispredicted branch is discarded.
      for (int e = 0; e < ROB_SIZE; e++) rob[e].busy <= 1'b0;
      head <= head + PTR_W'(rt_count);
      tail <= head + PTR_W'(rt_count);
    end else begin
      for (int c = 0; c < CDB_WIDTH; c++) begin
        if (cdb_valid[c] && rob[cdb_tag[c*TAG_W +: TAG_W]].busy) begin
          rob[cdb_tag[c*TAG_W +: TAG_W]].complete   <= 1'b1;
          rob[cdb_tag[c*TAG_W +: TAG_W]].value      <= cdb_value[c*XLEN +: XLEN];
          rob[cdb_tag[c*TAG_W +: TAG_W]].mispredict <= cdb_mispredict[c];
          rob[cdb_tag[c*TAG_W +: TAG_W]].target     <= cdb_target[c*XLEN +: XLEN];
        end
      end
      for (int j = 0; j < RT_WIDTH; j++) begin
        if (rt_valid[j]) rob[win_idx[j]].busy <= 1'b0;
      end
      if (dp_accept) begin
        for (int i = 0; i < DP_WIDTH; i++) begin
          if (dp_valid[i]) begin
            rob[tail[TAG_W-1:0] + TAG_W'(i)] <= '{
              busy:       1'b1,
              complete:   1'b0,
              mispredict: 1'b0,
              dest_reg:   dp_dest_reg[i*REG_W +: REG_W],
              pc:         dp_pc[i*XLEN +: XLEN],
              value:      '0,
              target:     '0
            };
          end
        end
        tail <= tail + dp_num;
      end
      head <= head + PTR_W'(rt_count);
    end
  end

endmodule

// File: tb/tb_rob_superscalar.sv
// Directed bench for rob_superscalar with default parameters (32 entries, 2/2/2 lanes).
module tb_rob_superscalar;
  import rob_pkg::*;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   dp_valid;
  logic [9:0]   dp_dest_reg;
  logic [63:0]  dp_pc;
  logic         dp_accept;
  logic [9:0]   dp_tag;
  logic [19:0]  src_tag;
  logic [3:0]   src_ready;
  logic [127:0] src_value;
  logic [1:0]   cdb_valid;
  logic [9:0]   cdb_tag;
  logic [63:0]  cdb_value;
  logic [1:0]   cdb_mispredict;
  logic [63:0]  cdb_target;
  logic [1:0]   rt_valid;
  logic [9:0]   rt_dest_reg;
  logic [63:0]  rt_value;
  logic [9:0]   rt_tag;
  logic         squash;
  logic [31:0]  squash_pc;
  logic [5:0]   count;
  logic         empty;
  rob_state_e   fsm_state;

  int checks   = 0;
  int failures = 0;

  rob_superscalar dut (
    .clock          (clock),
    .reset          (reset),
    .dp_valid       (dp_valid),
    .dp_dest_reg    (dp_dest_reg),
    .dp_pc          (dp_pc),
    .dp_accept      (dp_accept),
    .dp_tag         (dp_tag),
    .src_tag        (src_tag),
    .src_ready      (src_ready),
    .src_value      (src_value),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_value      (cdb_value),
    .cdb_mispredict (cdb_mispredict),
    .cdb_target     (cdb_target),
    .rt_valid       (rt_valid),
    .rt_dest_reg    (rt_dest_reg),
    .rt_value       (rt_value),
    .rt_tag         (rt_tag),
    .squash         (squash),
    .squash_pc      (squash_pc),
    .count          (count),
    .empty          (empty),
    .fsm_state      (fsm_state)
  );

  // Clock and reset
  always #5 clock = ~clock;

  // Two CDBs must never carry the same tag in one cycle.
  always @(negedge clock) begin
    if (!reset && cdb_valid == 2'b11) begin
      checks++;
      assert (cdb_tag[4:0] !== cdb_tag[9:5]) else begin
        failures++;
        $error("FAIL cdb_dup_tag observed=0x%0h expected=distinct", cdb_tag);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dp_valid       = '0;
    dp_dest_reg    = '0;
    dp_pc          = '0;
    src_tag        = '0;
    cdb_valid      = '0;
    cdb_tag        = '0;
    cdb_value      = '0;
    cdb_mispredict = '0;
    cdb_target     = '0;
  endtask

  task automatic cdb_drive(input int c, input logic [4:0] t, input logic [31:0] v,
                           input logic m, input logic [31:0] tgt);
    cdb_valid[c]           = 1'b1;
    cdb_tag[c*5 +: 5]      = t;
    cdb_value[c*32 +: 32]  = v;
    cdb_mispredict[c]      = m;
    cdb_target[c*32 +: 32] = tgt;
  endtask

  initial begin
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_accept", 64'(dp_accept), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_rt_valid", 64'(rt_valid), 64'd0);
    check("rst_squash", 64'(squash), 64'd0);
    check("rst_squash_pc", 64'(squash_pc), 64'd0);
    check("rst_dp_tag", 64'(dp_tag), 64'({5'd1, 5'd0}));
    check("rst_state", 64'(fsm_state), 64'(NORMAL));

    // Fill from reset: two per cycle, tag t gets dest t[4:0].
    for (int c = 0; c < 16; c++) begin
      idle();
      dp_valid    = 2'b11;
      dp_dest_reg = {5'(2*c+1), 5'(2*c)};
      dp_pc       = {32'(256 + 8*c + 4), 32'(256 + 8*c)};
      #1;
      check("fill_tag", 64'(dp_tag), 64'({5'(2*c+1), 5'(2*c)}));
      check("fill_accept", 64'(dp_accept), 64'd1);
      check("fill_count", 64'(count), 64'(2*c));
      tick();
    end
    idle();
    #1;
    check("full_count", 64'(count), 64'd32);
    check("full_accept", 64'(dp_accept), 64'd0);
    check("full_empty", 64'(empty), 64'd0);
    dp_valid = 2'b11;
    tick();
    idle();
    #1;
    check("full_hold", 64'(count), 64'd32);

    // Out-of-order completion 3,1,0,2.
    cdb_drive(0, 5'd3, 32'hA000_0003, 1'b0, 32'h0);
    src_tag[4:0] = 5'd3;
    #1;
    check("ooo3_rt", 64'(rt_valid), 64'd0);
    check("ooo3_byp_rdy", 64'(src_ready[0]), 64'd1);
    check("ooo3_byp_val", 64'(src_value[31:0]), 64'hA000_0003);
    tick();
    idle();
    cdb_drive(0, 5'd1, 32'hA000_0001, 1'b0, 32'h0);
    #1;
    check("ooo1_rt", 64'(rt_valid), 64'd0);
    tick();
    idle();
    cdb_drive(0, 5'd0, 32'hA000_0000, 1'b0, 32'h0);
    #1;
    check("ooo0_rt", 64'(rt_valid), 64'd0);
    tick();
    idle();
    cdb_drive(0, 5'd2, 32'hA000_0002, 1'b0, 32'h0);
    #1;
    check("ret01_valid", 64'(rt_valid), 64'd3);
    check("ret01_tag", 64'(rt_tag), 64'({5'd1, 5'd0}));
    check("ret01_value", rt_value, {32'hA000_0001, 32'hA000_0000});
    check("ret01_dest", 64'(rt_dest_reg), 64'({5'd1, 5'd0}));
    check("ret01_count", 64'(count), 64'd32);
    tick();
    idle();
    #1;
    check("ret23_valid", 64'(rt_valid), 64'd3);
    check("ret23_tag", 64'(rt_tag), 64'({5'd3, 5'd2}));
    check("ret23_count", 64'(count), 64'd30);
    tick();
    idle();
    #1;
    check("ret_none", 64'(rt_valid), 64'd0);
    check("ret_count", 64'(count), 64'd28);

    // Bypass: slot0 tag5 on CDB0, slot1 tag6 idle, slot2 tag3 retired, slot3 tag7 on CDB1.
    src_tag = {5'd7, 5'd3, 5'd6, 5'd5};
    cdb_drive(0, 5'd5, 32'hDEAD_BEEF, 1'b0, 32'h0);
    cdb_drive(1, 5'd7, 32'h0000_0077, 1'b0, 32'h0);
    #1;
    check("byp_ready", 64'(src_ready), 64'b1001);
    check("byp_val0", 64'(src_value[31:0]), 64'hDEAD_BEEF);
    check("byp_val1", 64'(src_value[63:32]), 64'd0);
    check("byp_val3", 64'(src_value[127:96]), 64'h77);
    tick();
    idle();
    src_tag[4:0] = 5'd5;
    #1;
    check("entry_rdy", 64'(src_ready[0]), 64'd1);
    check("entry_val", 64'(src_value[31:0]), 64'hDEAD_BEEF);
    check("entry_rt", 64'(rt_valid), 64'd0);
    tick();

    // Mispredict on lane 0 (head tag 4); tag 5 behind it is complete but must not retire.
    idle();
    cdb_drive(0, 5'd4, 32'hA000_0004, 1'b1, 32'h0000_1000);
    #1;
    check("mp_pre_rt", 64'(rt_valid), 64'd0);
    tick();
    idle();
    dp_valid = 2'b11;
    cdb_drive(0, 5'd6, 32'hA000_0006, 1'b0, 32'h0);
    #1;
    check("mp_squash", 64'(squash), 64'd1);
    check("mp_squash_pc", 64'(squash_pc), 64'h1000);
    check("mp_rt_valid", 64'(rt_valid), 64'b01);
    check("mp_rt_tag", 64'(rt_tag[4:0]), 64'd4);
    tick();
    #1;
    check("rec_count", 64'(count), 64'd0);
    check("rec_empty", 64'(empty), 64'd1);
    check("rec_accept", 64'(dp_accept), 64'd0);
    check("rec_state", 64'(fsm_state), 64'(RECOVER));
    check("rec_squash", 64'(squash), 64'd0);
    check("rec_dp_tag", 64'(dp_tag), 64'({5'd6, 5'd5}));
    tick();
    idle();
    src_tag[4:0] = 5'd6;
    #1;
    check("post_accept", 64'(dp_accept), 64'd1);
    check("post_count", 64'(count), 64'd0);
    check("post_state", 64'(fsm_state), 64'(NORMAL));
    check("post_src6", 64'(src_ready[0]), 64'd0);

    // Wrap: 40 dispatch/complete/retire rounds starting at tag 5.
    for (int k = 0; k < 40; k++) begin
      logic [4:0] t;
      t = 5'(5 + k);
      idle();
      dp_valid          = 2'b01;
      dp_dest_reg[4:0]  = 5'(k);
      #1;
      check("wrap_tag", 64'(dp_tag[4:0]), 64'(t));
      check("wrap_empty0", 64'(empty), 64'd1);
      tick();
      idle();
      cdb_drive(0, t, 32'h5000 + 32'(k), 1'b0, 32'h0);
      #1;
      check("wrap_count", 64'(count), 64'd1);
      check("wrap_empty1", 64'(empty), 64'd0);
      check("wrap_rt0", 64'(rt_valid), 64'd0);
      tick();
      idle();
      #1;
      check("wrap_rt1", 64'(rt_valid), 64'b01);
      check("wrap_rt_tag", 64'(rt_tag[4:0]), 64'(t));
      check("wrap_rt_val", 64'(rt_value[31:0]), 64'(32'h5000 + 32'(k)));
      tick();
    end

    // Reset mid-flight with ten entries in use and a CDB active.
    for (int c = 0; c < 5; c++) begin
      idle();
      dp_valid = 2'b11;
      tick();
    end
    idle();
    #1;
    check("mid_count", 64'(count), 64'd10);
    reset    = 1'b1;
    dp_valid = 2'b11;
    cdb_drive(0, 5'd13, 32'h1234_5678, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    idle();
    src_tag[4:0] = 5'd13;
    #1;
    check("mrst_count", 64'(count), 64'd0);
    check("mrst_empty", 64'(empty), 64'd1);
    check("mrst_rt", 64'(rt_valid), 64'd0);
    check("mrst_dp_tag", 64'(dp_tag), 64'({5'd1, 5'd0}));
    check("mrst_accept", 64'(dp_accept), 64'd1);
    check("mrst_src13", 64'(src_ready[0]), 64'd0);
    tick();

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rob_superscalar.md
Name: rob_superscalar

Overview:
- Parametrised N-way reorder buffer for the out-of-order core.
- Each cycle it:
  - allocates up to DP_WIDTH entries in program order from dispatch;
  - accepts up to CDB_WIDTH completions from the CDBs;
  - retires up to RT_WIDTH contiguous completed entries from the head.
- Supplies operand values (with CDB bypass) to the RS. Performs precise branch-mispredict recovery with a one-cycle recovery state.
- Sits between dispatch/map-table, the reservation stations, the CDB arbiter and the architectural register file.

Parameters:
- ROB_SIZE, 32, number of entries; power of two, >= 4.
- DP_WIDTH, 2, dispatch lanes per cycle.
- CDB_WIDTH, 2, completion buses per cycle.
- RT_WIDTH, 2, retire lanes per cycle.
- XLEN, 32, data/PC width.
- REG_W, 5, architectural register index width.
- TAG_W, $clog2(ROB_SIZE), ROB tag width (derived).

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- dp_valid  in  DP_WIDTH  per-lane allocate request; set lanes are contiguous from lane 0.
- dp_dest_reg  in  DP_WIDTH*REG_W  destination register per lane; 0 means no writeback.
- dp_pc  in  DP_WIDTH*XLEN  PC per lane.
- dp_accept  out  1  ROB can take a full dispatch group this cycle.
- dp_tag  out  DP_WIDTH*TAG_W  tag assigned to lane i: tail+i, modulo ROB_SIZE.
- src_tag  in  2*DP_WIDTH*TAG_W  operand tags to look up, two per dispatch lane.
- src_ready  out  2*DP_WIDTH  looked-up entry is complete, or is being broadcast on a CDB this cycle.
- src_value  out  2*DP_WIDTH*XLEN  value for the matching src_ready; 0 when not ready.
- cdb_valid  in  CDB_WIDTH  completion valid.
- cdb_tag  in  CDB_WIDTH*TAG_W  completing entry.
- cdb_value  in  CDB_WIDTH*XLEN  result.
- cdb_mispredict  in  CDB_WIDTH  branch resolved mispredicted.
- cdb_target  in  CDB_WIDTH*XLEN  correct next PC for a mispredicted branch.
- rt_valid  out  RT_WIDTH  retiring this cycle; lanes contiguous from lane 0.
- rt_dest_reg  out  RT_WIDTH*REG_W  retiring destination.
- rt_value  out  RT_WIDTH*XLEN  retiring value.
- rt_tag  out  RT_WIDTH*TAG_W  retiring tag, for map-table clear.
- squash  out  1  mispredicted branch retiring this cycle; flush everything younger.
- squash_pc  out  XLEN  redirect PC; valid when squash=1.
- count  out  TAG_W+1  occupied entries.
- empty  out  1  count==0.

Behaviour:
- State:
  - Per-entry fields: busy, complete, mispredict, dest_reg, pc, value, target.
  - head and tail pointers, each TAG_W+1 bits; the extra MSB disambiguates wrap-around.
  - count = tail-head, width TAG_W+1.
  - FSM with states NORMAL and RECOVER.
- Reset:
  - All entries cleared; head=tail=0; FSM=NORMAL.
  - Outputs after reset: dp_accept=1, count=0, empty=1, rt_valid=0, squash=0, squash_pc=0, dp_tag lane i = i.
  - Reset asserted mid-operation overrides every other event that cycle.
- Dispatch:
  - dp_accept = (FSM==NORMAL) && (ROB_SIZE-count >= DP_WIDTH), evaluated on registered count. Space freed by a same-cycle retire does not count.
  - When dp_accept=1, each lane with dp_valid set writes entry tail+i with busy=1, complete=0, mispredict=0, and tail advances by popcount(dp_valid).
  - When dp_accept=0, dp_valid is ignored and tail holds.
- Completion:
  - A CDB write to entry cdb_tag sets complete=1 and stores value, mispredict and target.
  - A write to a non-busy entry is ignored.
  - Two CDBs carrying the same tag in one cycle is illegal (bench asserts).
  - complete is registered, so an entry completed in cycle t retires no earlier than t+1.
- Retire (NORMAL only):
  - Lane j retires entry head+j if that entry and all of lanes 0..j-1 are busy && complete, and no lower lane is mispredicted.
  - Retiring entries clear busy; head advances by the number retired.
- Mispredict:
  - If a retiring lane's entry has mispredict=1, that lane retires (rt_valid=1) and squash=1, squash_pc=target, all combinationally in the same cycle. Higher lanes do not retire.
  - Next edge: all busy bits clear; tail=head=the retired-through pointer; count=0; FSM goes to RECOVER.
  - Dispatch and CDB inputs in the squash cycle are ignored.
  - RECOVER lasts exactly one cycle: dp_accept=0, no retire, CDB ignored. Then FSM returns to NORMAL.
- Operand lookup (combinational):
  - src_ready/src_value come from the entry when it is busy && complete.
  - Otherwise, a CDB with a matching tag this cycle supplies them (bypass); the lowest-indexed CDB wins.
  - If neither applies: ready=0, value=0.
- Wrap-around: tag = pointer[TAG_W-1:0].
  - Full: count==ROB_SIZE.
  - Empty: head==tail, both pointers' MSBs included.

Decomposition:
- A shared package rob_pkg holds:
  - the rob_entry_t struct (busy, complete, mispredict, dest_reg, pc, value, target);
  - the rob_state_e enum (NORMAL, RECOVER);
  - default width constants.
- One sub-module, rob_retire_select: combinational head-window scan producing rt_valid, the retire count and the squash lane (first mispredicted retiring lane).

Test Plan:
- Fill from reset: dispatch 2/cycle for 16 cycles, no CDB -> tags 0..31 assigned in order; count=32; dp_accept=0 once count>30.
- Out-of-order completion: complete tags 3,1,0,2 in successive cycles -> nothing retires until tag 0 is complete. Then 0,1 retire together the cycle after tag 0's completion; 2,3 retire the next cycle.
- Bypass: src_tag=5 while cdb_tag=5, cdb_value=0xDEAD_BEEF -> src_ready=1 and src_value=0xDEADBEEF in the same cycle.
- Mispredict on lane 0: head entry completes with mispredict, target=0x1000 -> squash=1, squash_pc=0x1000, rt_valid=01. Next cycle count=0, dp_accept=0. The cycle after, dp_accept=1.
- Wrap: run 40 dispatch/retire pairs -> tags wrap 31->0; count stays correct; empty is never falsely asserted.
- Reset mid-flight with count=10 and cdb_valid high -> next cycle count=0, empty=1, rt_valid=0.
